// File: rtl/dma_capture_pkg.sv
// Shared types and constants for the DMA frame capture block.
//   cap_state_t      : capture FSM state encoding
//   TEST_PATTERN_TAG : upper 16 bits of the generated test-pattern word
package dma_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam logic [15:0] TEST_PATTERN_TAG = 16'hA5A5;

endpackage

// File: rtl/dma_capture_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage.
// Words are written into a RAM ring; the head word is moved into an output
// register, so a word written at edge k is visible at the output after edge
// k+1 when the FIFO was empty. One beat per cycle is sustained while rd_ready
// stays high.
//
// Ports:
//   clk, rst_i  : clock, asynchronous active-high reset
//   wr_en       : write strobe (ignored when no room)
//   wr_data     : write word
//   rd_ready    : consumer accepts the output word this cycle
//   rd_valid    : output word valid
//   rd_data     : output word
//   full        : occupancy (RAM + output register) equals FIFO_DEPTH
//   empty       : nothing stored
module dma_capture_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           mem_cnt;
  logic [AW:0]           occ;
  logic                  pop;
  logic                  load;
  logic                  push;

  assign pop   = rd_valid & rd_ready;
  // Refill the output register whenever it is empty or being consumed.
  assign load  = (mem_cnt != '0) && (!rd_valid || pop);
  assign occ   = mem_cnt + (AW+1)'(rd_valid);
  assign full  = (occ == (AW+1)'(FIFO_DEPTH));
  assign empty = (occ == '0);
  // A pop on the same edge frees a slot, so a write into a full FIFO succeeds.
  assign push  = wr_en & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (load) begin
        rd_ptr   <= rd_ptr + AW'(1);
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_ptr];
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      case ({push, load})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/dma_frame_capture.sv
// Capture stage behind the PDH core's DMA tap. On a rising edge of enable_i
// it samples data_i every dec_r cycles until FRAME_LEN samples have been
// written to the internal FIFO, then streams them out as one AXI4-Stream
// packet with tlast on the final beat.
//
// Build option: define DMA_FRAME_CAPTURE_TEST_PATTERN_EN to write
// {A5A5, frame_index[15:0], sample_index[31:0]} instead of data_i.
//
// Ports:
//   clk, rst_i          : clock, asynchronous active-high reset
//   enable_i            : capture request (level; a 0->1 edge starts a frame)
//   data_i              : sample word, valid every cycle
//   decimation_code_i   : sample period in cycles (0 behaves as 1)
//   engaged_o           : frame in CAPTURE or DRAIN
//   finished_o          : frame fully streamed, held until enable_i low
//   overflow_o          : sticky, a sample was dropped this frame
//   m_axis_*            : AXI4-Stream master
//   state_o             : current FSM state, for observation
//
// Stream handshake: a beat transfers on a rising clk edge where tvalid and
// tready are both high. Once tvalid is high, tvalid/tdata/tlast hold until
// that transfer; tvalid never depends on tready in the same cycle.
module dma_frame_capture
  import dma_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEC_WIDTH  = 22,
  parameter int FRAME_LEN  = 4096,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DEC_WIDTH-1:0]  decimation_code_i,
  output logic                  engaged_o,
  output logic                  finished_o,
  output logic                  overflow_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output cap_state_t            state_o
);

  localparam int SCW = $clog2(FRAME_LEN);
  localparam logic [SCW-1:0] LAST_IDX = SCW'(FRAME_LEN - 1);

  cap_state_t            state_q;
  cap_state_t            state_d;
  logic                  en_q;
  logic                  rise;
  logic [DEC_WIDTH-1:0]  dec_r;
  logic [DEC_WIDTH-1:0]  dec_cnt;
  logic [DEC_WIDTH-1:0]  dec_next;
  logic [SCW-1:0]        sample_cnt;
  logic [SCW-1:0]        beat_cnt;
  logic                  take;
  logic                  wr_ok;
  logic                  wr_en;
  logic                  drop;
  logic                  last_write;
  logic                  accept;
  logic                  tlast_accept;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  unused_fifo_empty;
  logic [DATA_WIDTH-1:0] wr_data;

  assign rise         = enable_i & ~en_q;
  assign take         = (state_q == CAPTURE) && (dec_cnt == '0);
  // Full only blocks the write when no beat leaves on this edge.
  assign wr_ok        = ~fifo_full | accept;
  assign wr_en        = take & wr_ok;
  assign drop         = take & ~wr_ok;
  assign last_write   = wr_en && (sample_cnt == LAST_IDX);
  assign accept       = m_axis_tvalid & m_axis_tready;
  assign tlast_accept = accept & m_axis_tlast;
  // tlast comes from the output-side beat count, not from stored flags.
  assign m_axis_tlast = m_axis_tvalid && (beat_cnt == LAST_IDX);
  assign unused_fifo_empty = fifo_empty;

  // Decimation counter runs 0..dec_r-1; dec_r of 0 or 1 samples every cycle.
  always_comb begin
    dec_next = dec_cnt + DEC_WIDTH'(1);
    if (dec_r <= DEC_WIDTH'(1) || dec_cnt == dec_r - DEC_WIDTH'(1)) begin
      dec_next = '0;
    end
  end

`ifdef DMA_FRAME_CAPTURE_TEST_PATTERN_EN
  logic [15:0] frame_index;
  logic        unused_data;

  assign unused_data = ^data_i;
  assign wr_data = DATA_WIDTH'({TEST_PATTERN_TAG, frame_index, 32'(sample_cnt)});

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      frame_index <= '0;
    end else if (tlast_accept) begin
      frame_index <= frame_index + 16'd1;
    end
  end
`else
  assign wr_data = data_i;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_d    = state_q;
    engaged_o  = 1'b0;
    finished_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        engaged_o = 1'b1;
        if (last_write) state_d = DRAIN;
      end
      DRAIN: begin
        engaged_o = 1'b1;
        if (tlast_accept) state_d = DONE;
      end
      DONE: begin
        finished_o = 1'b1;
        if (!enable_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

  // Capture-side counters and sticky overflow
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      // Starting high means enable_i already high at reset release is not an edge.
      en_q       <= 1'b1;
      dec_r      <= '0;
      dec_cnt    <= '0;
      sample_cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      en_q <= enable_i;
      if (state_q == IDLE && rise) begin
        dec_r      <= decimation_code_i;
        dec_cnt    <= '0;
        sample_cnt <= '0;
        overflow_o <= 1'b0;
      end else if (state_q == CAPTURE) begin
        dec_cnt <= dec_next;
        if (wr_en) sample_cnt <= sample_cnt + SCW'(1);
        if (drop)  overflow_o <= 1'b1;
      end
    end
  end

  // Output-side beat counter, wraps on the tlast beat
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
    end else if (tlast_accept) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + SCW'(1);
    end
  end

  dma_capture_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_i    (rst_i),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_ready (m_axis_tready),
    .rd_valid (m_axis_tvalid),
    .rd_data  (m_axis_tdata),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
